// File: rtl/cxs_rxflit_wr_ctrl.sv
// CXS receive link-layer front end: activation handshake, credit issue and
// circular flit writes into the RX flit RAM. Optional counters: CXS_RXFLIT_STATS_EN.
module cxs_rxflit_wr_ctrl #(
    parameter int AWIDTH  = 12,
    parameter int WWIDTH  = 128,
    parameter int CWIDTH  = 14,
    parameter int DEPTH   = 64,
    parameter int MAX_CRD = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cxs_rx_activereq,
    output logic              cxs_rx_activeack,
    input  logic              cxs_rx_valid,
    input  logic [WWIDTH-1:0] cxs_rx_data,
    input  logic [CWIDTH-1:0] cxs_rx_cntl,
    input  logic              cxs_rx_crdrtn,
    output logic              cxs_rx_crdgnt,
    output logic              ram_en_a,
    output logic              ram_we_a,
    output logic [AWIDTH-1:0] ram_addr_a,
    output logic [WWIDTH-1:0] ram_wr_data_a,
    input  logic              slot_free,
    output logic [AWIDTH:0]   occupancy,
    output logic [AWIDTH-1:0] wr_ptr,
    output logic [CWIDTH-1:0] last_cntl,
    output logic              crd_err,
`ifdef CXS_RXFLIT_STATS_EN
    output logic [31:0]       rx_flit_cnt,
    output logic [15:0]       drop_cnt,
`endif
    output logic              link_up
);

    localparam int OW = AWIDTH + 1;
    localparam int SW = AWIDTH + 2;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_ACTIVATE,
        ST_RUN,
        ST_DEACTIVATE
    } state_t;

    state_t          state;
    logic [3:0]      crd_out;
    logic [3:0]      crd_after;
    logic [SW-1:0]   committed;
    logic            gnt;
    logic            acc;
    logic            drop;
    logic            rtn;
    logic            freed;
    logic [AWIDTH-1:0] ptr_next;

    // Slots already promised (filled or credited) bound the grant decision.
    always_comb begin
        committed = SW'(occupancy) + SW'(crd_out);
        gnt       = (state == ST_RUN) && (crd_out < 4'(MAX_CRD)) && (committed < SW'(DEPTH));
        acc       = cxs_rx_valid && (crd_out != 4'd0);
        drop      = cxs_rx_valid && (crd_out == 4'd0);
        crd_after = crd_out + 4'(gnt) - 4'(acc);
        // A return only counts while a credit is actually left to give back.
        rtn       = cxs_rx_crdrtn && (crd_out != 4'd0) && (crd_after != 4'd0);
        freed     = slot_free && (occupancy != '0);
        ptr_next  = (wr_ptr == AWIDTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end

    assign cxs_rx_crdgnt = gnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_STOP;
            cxs_rx_activeack <= 1'b0;
            link_up          <= 1'b0;
        end else begin
            case (state)
                ST_STOP: begin
                    if (cxs_rx_activereq) begin
                        state            <= ST_ACTIVATE;
                        cxs_rx_activeack <= 1'b1;
                    end
                end
                ST_ACTIVATE: begin
                    state   <= ST_RUN;
                    link_up <= 1'b1;
                end
                ST_RUN: begin
                    if (!cxs_rx_activereq) begin
                        state   <= ST_DEACTIVATE;
                        link_up <= 1'b0;
                    end
                end
                ST_DEACTIVATE: begin
                    if (crd_out == 4'd0) begin
                        state            <= ST_STOP;
                        cxs_rx_activeack <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_STOP;
                    cxs_rx_activeack <= 1'b0;
                    link_up          <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crd_out       <= 4'd0;
            occupancy     <= '0;
            wr_ptr        <= '0;
            ram_en_a      <= 1'b0;
            ram_we_a      <= 1'b0;
            ram_addr_a    <= '0;
            ram_wr_data_a <= '0;
            last_cntl     <= '0;
            crd_err       <= 1'b0;
        end else begin
            crd_out   <= crd_after - 4'(rtn);
            occupancy <= occupancy + OW'(acc) - OW'(freed);
            ram_en_a  <= acc;
            ram_we_a  <= acc;
            if (acc) begin
                ram_addr_a    <= wr_ptr;
                ram_wr_data_a <= cxs_rx_data;
                last_cntl     <= cxs_rx_cntl;
                wr_ptr        <= ptr_next;
            end
            if (drop) begin
                crd_err <= 1'b1;
            end
        end
    end

`ifdef CXS_RXFLIT_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_flit_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (acc) begin
                rx_flit_cnt <= rx_flit_cnt + 32'd1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cxs_rxflit_wr_ctrl.sv
// Self-checking bench for cxs_rxflit_wr_ctrl against a counter-level link model.
`define CHK(tag, obs, exp) \
    begin \
        total++; \
        assert ((obs) === (exp)) else begin \
            bad++; \
            $error("FAIL %s: got %0h want %0h", tag, (obs), (exp)); \
        end \
    end

module tb_cxs_rxflit_wr_ctrl;

    localparam int AW   = 12;
    localparam int WW   = 128;
    localparam int CW   = 14;
    localparam int DEP  = 64;
    localparam int MAXC = 15;
    localparam int OW   = AW + 1;

    logic          clk;
    logic          resetn;
    logic          cxs_rx_activereq;
    logic          cxs_rx_activeack;
    logic          cxs_rx_valid;
    logic [WW-1:0] cxs_rx_data;
    logic [CW-1:0] cxs_rx_cntl;
    logic          cxs_rx_crdrtn;
    logic          cxs_rx_crdgnt;
    logic          ram_en_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [WW-1:0] ram_wr_data_a;
    logic          slot_free;
    logic [AW:0]   occupancy;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] last_cntl;
    logic          crd_err;
    logic          link_up;
`ifdef CXS_RXFLIT_STATS_EN
    logic [31:0]   rx_flit_cnt;
    logic [15:0]   drop_cnt;
`endif

    cxs_rxflit_wr_ctrl #(
        .AWIDTH(AW), .WWIDTH(WW), .CWIDTH(CW), .DEPTH(DEP), .MAX_CRD(MAXC)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cxs_rx_activereq(cxs_rx_activereq),
        .cxs_rx_activeack(cxs_rx_activeack),
        .cxs_rx_valid(cxs_rx_valid),
        .cxs_rx_data(cxs_rx_data),
        .cxs_rx_cntl(cxs_rx_cntl),
        .cxs_rx_crdrtn(cxs_rx_crdrtn),
        .cxs_rx_crdgnt(cxs_rx_crdgnt),
        .ram_en_a(ram_en_a),
        .ram_we_a(ram_we_a),
        .ram_addr_a(ram_addr_a),
        .ram_wr_data_a(ram_wr_data_a),
        .slot_free(slot_free),
        .occupancy(occupancy),
        .wr_ptr(wr_ptr),
        .last_cntl(last_cntl),
        .crd_err(crd_err),
`ifdef CXS_RXFLIT_STATS_EN
        .rx_flit_cnt(rx_flit_cnt),
        .drop_cnt(drop_cnt),
`endif
        .link_up(link_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Link model: phase 0 STOP, 1 ACTIVATE, 2 RUN, 3 DEACTIVATE.
    int          mst;
    int          mcrd;
    int          mocc;
    int          mptr;
    logic        merr;
    logic [CW-1:0] mcntl;
    int          gnt_seen;
    logic [31:0] mflits;
    int          mdrops;

    function automatic logic [WW-1:0] rdata();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        mst = 0; mcrd = 0; mocc = 0; mptr = 0; merr = 1'b0; mcntl = '0;
        mflits = 0; mdrops = 0;
    endtask

    task automatic idle_inputs();
        cxs_rx_valid = 1'b0; cxs_rx_crdrtn = 1'b0; slot_free = 1'b0;
    endtask

    task automatic rst_chk(string tag);
        logic ok;
        ok = (cxs_rx_activeack === 1'b0) && (cxs_rx_crdgnt === 1'b0) &&
             (ram_we_a === 1'b0) && (ram_en_a === 1'b0) &&
             (occupancy === OW'(0)) && (wr_ptr === AW'(0)) &&
             (crd_err === 1'b0) && (link_up === 1'b0);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL reset state %s: ack=%0b gnt=%0b we=%0b en=%0b occ=%0h ptr=%0h err=%0b up=%0b",
                   tag, cxs_rx_activeack, cxs_rx_crdgnt, ram_we_a, ram_en_a,
                   occupancy, wr_ptr, crd_err, link_up);
        end
    endtask

    task automatic wait_chk(string tag, bit done);
        total++;
        if (!done) begin
            bad++;
            $error("FAIL wait expired: %s", tag);
        end
    endtask

    // One clock: check the grant, predict the cycle, then check registered outputs.
    task automatic tick();
        logic egnt, eacc, edrop, efree;
        int ecrd, nst, eaddr;
        logic [WW-1:0] edata;
        logic [CW-1:0] ecntl;
        egnt = (mst == 2) && (mcrd < MAXC) && (mocc + mcrd < DEP);
        `CHK("crdgnt", cxs_rx_crdgnt, egnt)
        if (cxs_rx_crdgnt) gnt_seen++;
        eacc  = cxs_rx_valid && (mcrd > 0);
        edrop = cxs_rx_valid && (mcrd == 0);
        efree = slot_free && (mocc > 0);
        ecrd  = mcrd + int'(egnt) - int'(eacc);
        if (cxs_rx_crdrtn && mcrd > 0 && ecrd > 0) ecrd--;
        case (mst)
            0:       nst = cxs_rx_activereq ? 1 : 0;
            1:       nst = 2;
            2:       nst = cxs_rx_activereq ? 2 : 3;
            default: nst = (mcrd == 0) ? 0 : 3;
        endcase
        eaddr = mptr;
        edata = cxs_rx_data;
        ecntl = cxs_rx_cntl;
        @(posedge clk);
        #1;
        mcrd = ecrd;
        mocc = mocc + int'(eacc) - int'(efree);
        if (eacc) begin
            mptr   = (mptr + 1) % DEP;
            mcntl  = ecntl;
            mflits = mflits + 32'd1;
        end
        if (edrop) begin
            merr = 1'b1;
            if (mdrops < 65535) mdrops++;
        end
        mst = nst;
        `CHK("ram_en", ram_en_a, eacc)
        `CHK("ram_we", ram_we_a, eacc)
        if (eacc) begin
            `CHK("ram_addr", ram_addr_a, AW'(eaddr))
            `CHK("ram_data", ram_wr_data_a, edata)
        end
        `CHK("occupancy", occupancy, OW'(mocc))
        `CHK("wr_ptr", wr_ptr, AW'(mptr))
        `CHK("last_cntl", last_cntl, mcntl)
        `CHK("crd_err", crd_err, merr)
        `CHK("activeack", cxs_rx_activeack, (mst != 0))
        `CHK("link_up", link_up, (mst == 2))
`ifdef CXS_RXFLIT_STATS_EN
        `CHK("rx_flit_cnt", rx_flit_cnt, mflits)
        `CHK("drop_cnt", drop_cnt, 16'(mdrops))
`endif
    endtask

    initial begin
        int sent;
        resetn = 1'b0;
        cxs_rx_activereq = 1'b1;
        cxs_rx_data = '0;
        cxs_rx_cntl = '0;
        idle_inputs();
        model_reset();
        gnt_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_chk("initial");
        `CHK("rst_activeack", cxs_rx_activeack, 1'b0)
        `CHK("rst_crdgnt", cxs_rx_crdgnt, 1'b0)
        `CHK("rst_ram_we", ram_we_a, 1'b0)
        `CHK("rst_occupancy", occupancy, OW'(0))
        `CHK("rst_wr_ptr", wr_ptr, AW'(0))
        `CHK("rst_crd_err", crd_err, 1'b0)
        `CHK("rst_link_up", link_up, 1'b0)
        resetn = 1'b1;

        // Activation and the initial credit burst.
        for (int c = 0; c < 24; c++) tick();
        `CHK("init_grants", gnt_seen, MAXC)

        // Fill the whole ring with data = index.
        sent = 0;
        for (int c = 0; c < 400 && sent < DEP; c++) begin
            cxs_rx_valid = (mcrd > 0);
            cxs_rx_data  = WW'(sent);
            cxs_rx_cntl  = CW'($urandom);
            if (cxs_rx_valid) sent++;
            tick();
        end
        idle_inputs();
        wait_chk("fill", sent == DEP);
        `CHK("fill_sent", sent, DEP)
        for (int c = 0; c < 4; c++) tick();
        `CHK("fill_occupancy", occupancy, OW'(DEP))

        // Free three slots and write across the wrap point.
        gnt_seen = 0;
        for (int k = 0; k < 3; k++) begin
            slot_free = 1'b1; tick();
            slot_free = 1'b0; tick();
        end
        `CHK("wrap_grants", gnt_seen, 3)
        sent = 0;
        for (int c = 0; c < 50 && sent < 3; c++) begin
            cxs_rx_valid = (mcrd > 0);
            cxs_rx_data  = rdata();
            if (cxs_rx_valid) sent++;
            tick();
        end
        idle_inputs();
        wait_chk("wrap writes", sent == 3);
        tick();
        `CHK("wrap_wr_ptr", wr_ptr, AW'(3))

        // Drain to 10, then accept and free in the same cycle.
        for (int c = 0; c < 200 && mocc > 10; c++) begin
            slot_free = 1'b1; tick();
        end
        idle_inputs();
        wait_chk("drain to 10", mocc == 10);
        for (int c = 0; c < 20; c++) tick();
        cxs_rx_valid = 1'b1; slot_free = 1'b1; cxs_rx_data = rdata();
        tick();
        idle_inputs();
        `CHK("simul_occupancy", occupancy, OW'(10))

        // Valid + return each cycle walks credits down; at 5 the grant coincides.
        for (int c = 0; c < 40 && mcrd != 5; c++) begin
            cxs_rx_valid = 1'b1; cxs_rx_crdrtn = 1'b1; cxs_rx_data = rdata();
            tick();
        end
        wait_chk("credits down to 5", mcrd == 5);
        cxs_rx_valid = 1'b1; cxs_rx_crdrtn = 1'b1; cxs_rx_data = rdata();
        `CHK("gnt_at_5", cxs_rx_crdgnt, 1'b1)
        tick();
        idle_inputs();
        for (int c = 0; c < 6; c++) tick();

        // Randomised well-behaved traffic.
        for (int c = 0; c < 500; c++) begin
            cxs_rx_valid  = (mcrd > 0) && ($urandom_range(2) != 0);
            cxs_rx_crdrtn = (mcrd > 1) && ($urandom_range(7) == 0);
            slot_free     = ($urandom_range(2) == 0);
            cxs_rx_data   = rdata();
            cxs_rx_cntl   = CW'($urandom);
            tick();
        end
        idle_inputs();

        // Fill until no credit is left, then force a flit.
        for (int c = 0; c < 600 && !(mocc == DEP && mcrd == 0); c++) begin
            cxs_rx_valid = (mcrd > 0);
            cxs_rx_data  = rdata();
            tick();
        end
        idle_inputs();
        wait_chk("full with zero credits", (mocc == DEP) && (mcrd == 0));
        `CHK("full_occupancy", occupancy, OW'(DEP))
        cxs_rx_valid = 1'b1; cxs_rx_data = rdata();
        tick();
        idle_inputs();
        `CHK("crd_err_set", crd_err, 1'b1)
`ifdef CXS_RXFLIT_STATS_EN
        `CHK("drop_cnt_one", drop_cnt, 16'd1)
`endif
        for (int c = 0; c < 5; c++) tick();

        // Deactivate with four credits outstanding.
        for (int k = 0; k < 4; k++) begin
            slot_free = 1'b1; tick();
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) tick();
        cxs_rx_activereq = 1'b0;
        tick();
        gnt_seen = 0;
        for (int k = 0; k < 4; k++) begin
            cxs_rx_crdrtn = 1'b1; tick();
        end
        idle_inputs();
        `CHK("deact_ack_held", cxs_rx_activeack, 1'b1)
        tick();
        `CHK("deact_no_grants", gnt_seen, 0)
        `CHK("stop_activeack", cxs_rx_activeack, 1'b0)
        `CHK("stop_link_up", link_up, 1'b0)
        cxs_rx_crdrtn = 1'b1; tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) tick();
        `CHK("crd_err_sticky", crd_err, 1'b1)

        // Reset clears the sticky error; then abandon a write with async reset.
        resetn = 1'b0;
        #1;
        `CHK("rst2_crd_err", crd_err, 1'b0)
        rst_chk("second");
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cxs_rx_activereq = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        cxs_rx_valid = (mcrd > 0); cxs_rx_data = rdata();
        tick();
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;
        `CHK("async_ram_we", ram_we_a, 1'b0)
        `CHK("async_ram_en", ram_en_a, 1'b0)
        `CHK("async_occupancy", occupancy, OW'(0))
        @(posedge clk);
        #1;
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
